// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // True when a writing stage targets a real (non-x0) register equal to rs.
  function automatic logic reg_match(input logic [4:0] rd, input logic wen,
                                     input logic [4:0] rs);
    return wen && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_mem_fsm.sv
`default_nettype none
// ============================================================================
// Module   : hazard_mem_fsm
// Purpose  : Data-memory wait FSM; drives freeze and the sticky timeout flag.
// Revision : 1.0
// ============================================================================
module hazard_mem_fsm
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic dmem_req,
  input  logic dmem_ready,
  output logic freeze,
  output logic mem_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The final counted WAIT cycle is the timeout: freeze drops on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          freeze  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_err = err_q;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Stall/flush/forwarding control with memory-wait freeze.
//            HAZARD_FWD_EN selects forwarding; otherwise RAW hazards stall.
// Revision : 1.0
// ============================================================================
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             regwriteE,
  input  logic [1:0]       resultsrcE,
  input  logic             pcsrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             freeze,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             mem_err,
  output logic [WIDTH-1:0] stall_cnt
);

  logic [4:0]       rdM_q, rdM_d, rdW_q, rdW_d;
  logic             regwriteM_q, regwriteM_d, regwriteW_q, regwriteW_d;
  logic [WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic             hz;

  hazard_mem_fsm #(
    .MAX_WAIT (MAX_WAIT)
  ) u_mem_fsm (
    .clk        (clk),
    .rst        (rst),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .freeze     (freeze),
    .mem_err    (mem_err)
  );

  always_comb begin
    rdM_d       = rdM_q;
    regwriteM_d = regwriteM_q;
    rdW_d       = rdW_q;
    regwriteW_d = regwriteW_q;
    if (!freeze) begin
      rdM_d       = rdE;
      regwriteM_d = regwriteE;
      rdW_d       = rdM_q;
      regwriteW_d = regwriteM_q;
    end
  end

`ifdef HAZARD_FWD_EN
  function automatic fwd_sel_t fwd_sel(input logic [4:0] rs);
    if (reg_match(rdM_q, regwriteM_q, rs))      return FWD_M;
    else if (reg_match(rdW_q, regwriteW_q, rs)) return FWD_W;
    else                                        return FWD_RF;
  endfunction

  assign forwardAE = fwd_sel(rs1E);
  assign forwardBE = fwd_sel(rs2E);

  // A taken branch kills the decode instruction, so its load-use is moot.
  assign hz = (resultsrcE == RESULT_LOAD) && (rdE != 5'd0) &&
              ((rdE == rs1D) || (rdE == rs2D)) && !pcsrcE;
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1E, rs2E, resultsrcE};

  assign forwardAE = FWD_RF;
  assign forwardBE = FWD_RF;

  assign hz = (reg_match(rdE,   regwriteE,   rs1D) || reg_match(rdE,   regwriteE,   rs2D) ||
               reg_match(rdM_q, regwriteM_q, rs1D) || reg_match(rdM_q, regwriteM_q, rs2D) ||
               reg_match(rdW_q, regwriteW_q, rs1D) || reg_match(rdW_q, regwriteW_q, rs2D)) &&
              !pcsrcE;
`endif

  assign stallF = hz | freeze;
  assign stallD = hz | freeze;
  assign flushD = pcsrcE & !freeze;
  assign flushE = (hz | pcsrcE) & !freeze;

  assign stall_cnt_d = stallD ? stall_cnt_q + WIDTH'(1) : stall_cnt_q;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdM_q       <= 5'd0;
      regwriteM_q <= 1'b0;
      rdW_q       <= 5'd0;
      regwriteW_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      rdM_q       <= rdM_d;
      regwriteM_q <= regwriteM_d;
      rdW_q       <= rdW_d;
      regwriteW_q <= regwriteW_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire
